// File: rtl/match_pkg.sv
// Shared types for the match scorer: FSM state encoding and winner codes.
package match_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    POINT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } matchState_e;

  localparam logic WIN_LEFT  = 1'b0;
  localparam logic WIN_RIGHT = 1'b1;

endpackage

// File: rtl/round_hold_timer.sv
// Inter-round pause timer: a start pulse arms HOLD_CYCLES; done marks the last pause cycle.
module round_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(HOLD_CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/match_scorer.sv
// Two-player match scorer: awards points from edge/press coincidences, pauses between rounds,
// and latches the match result. Define MATCH_DEUCE_EN to require a two-point winning lead.
module match_scorer
  import match_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left_edge_on,
  input  logic               right_edge_on,
  input  logic               left_press,
  input  logic               right_press,
  output logic               round_over,
  output logic               round_winner,
  output logic               new_round,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               match_over,
  output logic               match_winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);
`ifdef MATCH_DEUCE_EN
  localparam logic [SCORE_W-1:0] DEUCE_VAL = SCORE_W'(WIN_SCORE - 1);
`endif

  matchState_e        state;
  logic [SCORE_W-1:0] leftScore;
  logic [SCORE_W-1:0] rightScore;
  logic               winnerReg;
  logic               leftHit;
  logic               rightHit;
  logic               winCond;
  logic               holdStart;
  logic               holdDone;

  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic isWin(input logic [SCORE_W-1:0] own,
                                 input logic [SCORE_W-1:0] other);
`ifdef MATCH_DEUCE_EN
    return (own >= WIN_VAL) && ({1'b0, own} >= {1'b0, other} + (SCORE_W+1)'(2));
`else
    return (own == WIN_VAL) && (other == other);
`endif
  endfunction

  assign rightHit = (state == PLAY) && right_edge_on && right_press && !left_press;
  assign leftHit  = (state == PLAY) && left_edge_on && left_press && !right_press;

  // Only the player who just scored can have reached the win condition.
  assign winCond   = (winnerReg == WIN_RIGHT) ? isWin(rightScore, leftScore)
                                              : isWin(leftScore, rightScore);
  assign holdStart = (state == POINT) && !winCond;

  round_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) uHoldTimer (
    .clk   (clk),
    .reset (reset),
    .start (holdStart),
    .done  (holdDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      leftScore  <= '0;
      rightScore <= '0;
      winnerReg  <= WIN_LEFT;
    end else begin
      case (state)
        PLAY: begin
          if (rightHit) begin
            rightScore <= satInc(rightScore);
            winnerReg  <= WIN_RIGHT;
            state      <= POINT;
          end else if (leftHit) begin
            leftScore <= satInc(leftScore);
            winnerReg <= WIN_LEFT;
            state     <= POINT;
          end
        end
        POINT: begin
          if (winCond) begin
            state <= DONE;
          end else begin
            state <= HOLD;
`ifdef MATCH_DEUCE_EN
            // Level scores past the target fold back so the counters stay bounded.
            if ((leftScore == rightScore) && (leftScore >= WIN_VAL)) begin
              leftScore  <= DEUCE_VAL;
              rightScore <= DEUCE_VAL;
            end
`endif
          end
        end
        HOLD: begin
          if (holdDone) state <= PLAY;
        end
        DONE: state <= DONE;
        default: state <= PLAY;
      endcase
    end
  end

  assign round_over   = (state == POINT);
  assign round_winner = round_over & winnerReg;
  assign new_round    = (state == HOLD) & holdDone;
  assign match_over   = (state == DONE);
  assign match_winner = match_over & winnerReg;
  assign left_score   = leftScore;
  assign right_score  = rightScore;

endmodule

// File: tb/tb_match_scorer.sv
// Bench for match_scorer: directed scenarios plus randomized play against a timeline model.
module tb_match_scorer;

  localparam int SW = 3;
  localparam int WS = 5;
  localparam int HC = 4;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          lEdge, rEdge, lPress, rPress;
  logic          round_over, round_winner, new_round, match_over, match_winner;
  logic [SW-1:0] left_score, right_score;

  int checks = 0;
  int fails  = 0;

  // Timeline model: cycle n is the interval after the n-th clock edge.
  int n = 0;
  int mL = 0, mR = 0, mWinner = 0, decided = 0;
  int pointCyc = -1, newRoundCyc = -1, deuceFrom = -1;
  int doneFrom = NEVER, acceptFrom = NEVER;

  match_scorer #(
    .SCORE_W    (SW),
    .WIN_SCORE  (WS),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .left_edge_on (lEdge),
    .right_edge_on(rEdge),
    .left_press   (lPress),
    .right_press  (rPress),
    .round_over   (round_over),
    .round_winner (round_winner),
    .new_round    (new_round),
    .left_score   (left_score),
    .right_score  (right_score),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit wins(input int own, input int other);
`ifdef MATCH_DEUCE_EN
    return (own >= WS) && (own - other >= 2);
`else
    return (own == WS) && (other >= 0);
`endif
  endfunction

  function automatic bit levelPastTarget(input int l, input int r);
`ifdef MATCH_DEUCE_EN
    return (l == r) && (l >= WS);
`else
    return (l < 0) && (r < 0);
`endif
  endfunction

  function automatic bit accepting();
    return (decided == 0) && (n >= acceptFrom);
  endfunction

  task automatic modelEdge(input bit rst, input bit le, input bit re, input bit lp, input bit rp);
    bit rightPt, leftPt;
    int own, other;
    n++;
    if (rst) begin
      mL = 0; mR = 0; mWinner = 0; decided = 0;
      pointCyc = -1; newRoundCyc = -1; deuceFrom = -1;
      doneFrom = NEVER; acceptFrom = n;
    end else begin
      if (n == deuceFrom) begin
        mL = WS - 1;
        mR = WS - 1;
      end
      if (decided == 0 && (n - 1) >= acceptFrom) begin
        rightPt = re && rp && !lp;
        leftPt  = le && lp && !rp;
        if (rightPt || leftPt) begin
          mWinner  = rightPt ? 1 : 0;
          if (rightPt) mR++; else mL++;
          pointCyc = n;
          own   = rightPt ? mR : mL;
          other = rightPt ? mL : mR;
          if (wins(own, other)) begin
            decided    = 1;
            doneFrom   = n + 1;
            acceptFrom = NEVER;
          end else begin
            if (levelPastTarget(mL, mR)) deuceFrom = n + 1;
            newRoundCyc = n + HC;
            acceptFrom  = n + HC + 1;
          end
        end
      end
    end
  endtask

  task automatic checkOutputs();
    chk("round_over",   round_over,   (n == pointCyc) ? 1 : 0);
    chk("round_winner", round_winner, (n == pointCyc) ? mWinner : 0);
    chk("new_round",    new_round,    (n == newRoundCyc) ? 1 : 0);
    chk("left_score",   left_score,   mL);
    chk("right_score",  right_score,  mR);
    chk("match_over",   match_over,   (n >= doneFrom) ? 1 : 0);
    chk("match_winner", match_winner, (n >= doneFrom) ? mWinner : 0);
  endtask

  task automatic cycle(input bit rst, input bit le, input bit re, input bit lp, input bit rp);
    reset = rst; lEdge = le; rEdge = re; lPress = lp; rPress = rp;
    @(posedge clk);
    modelEdge(rst, le, re, lp, rp);
    #1;
    checkOutputs();
  endtask

  task automatic scorePoint(input bit right);
    int waited = 0;
    while (!accepting() && waited < 40) begin
      cycle(0, 0, 0, 0, 0);
      waited++;
    end
    if (!accepting()) begin
      checks++;
      fails++;
      $error("FAIL accept_wait observed=%0d expected=%0d", waited, 40);
    end
    cycle(0, !right, right, !right, right);
  endtask

  initial begin
    int sawNewRound;
    bit rr;
    reset = 1'b1; lEdge = 0; rEdge = 0; lPress = 0; rPress = 0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_left", left_score, 0);
    chk("rst_match_over", match_over, 0);

    // Right point, then pause ending in new_round four cycles after round_over.
    cycle(0, 0, 1, 0, 1);
    chk("r027_round_over", round_over, 1);
    chk("r027_round_winner", round_winner, 1);
    chk("r027_right_score", right_score, 1);
    for (int k = 1; k <= HC; k++) cycle(0, 0, 0, 0, 0);
    chk("r027_new_round", new_round, 1);

    // Simultaneous presses and a press without the edge lit score nothing.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1);
    chk("r028_round_over", round_over, 0);
    cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 0);
    chk("r028_left", left_score, 0);
    chk("r028_right", right_score, 0);

    // Presses during HOLD are ignored.
    scorePoint(0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 1, 1, 0);
    chk("r029_hold_left", left_score, 1);
    chk("r029_hold_right", right_score, 0);

    // Left wins 5-0; result holds, presses in DONE are ignored, no new_round.
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < WS; k++) scorePoint(0);
    cycle(0, 0, 0, 0, 0);
    chk("r030_match_over", match_over, 1);
    chk("r030_match_winner", match_winner, 0);
    chk("r030_left", left_score, WS);
    sawNewRound = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 1, k[0], !k[0]);
      if (new_round) sawNewRound++;
    end
    chk("r030_no_new_round", sawNewRound, 0);
    chk("r029_done_left", left_score, WS);
    chk("r029_done_right", right_score, 0);

    // Reset in DONE, then reset mid-HOLD; play resumes immediately each time.
    cycle(1, 0, 0, 0, 0);
    chk("r032_done_left", left_score, 0);
    chk("r032_done_match_over", match_over, 0);
    scorePoint(1);
    chk("r032_done_point", right_score, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("r032_hold_right", right_score, 0);
    cycle(0, 1, 0, 1, 0);
    chk("r032_hold_point", left_score, 1);
    chk("r032_hold_round_over", round_over, 1);

`ifdef MATCH_DEUCE_EN
    // 5/5 folds to 4/4, then two left points win 6/4.
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < WS; k++) begin
      scorePoint(0);
      scorePoint(1);
    end
    cycle(0, 0, 0, 0, 0);
    chk("r031_fold_left", left_score, WS - 1);
    chk("r031_fold_right", right_score, WS - 1);
    scorePoint(0);
    scorePoint(0);
    cycle(0, 0, 0, 0, 0);
    chk("r031_match_over", match_over, 1);
    chk("r031_left", left_score, WS + 1);
`endif

    // Randomized play with occasional resets.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rr = (i % 80 == 79) || ($urandom_range(0, 150) == 0);
      cycle(rr, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
